buzzer_sequencer: RTL and testbench

- Parametrised single-voice buzzer music sequencer. It is the successor to the fixed 8-bit, two-ROM music player.
- Walks a song stored as packed note words in an external synchronous memory, starting at a supplied address and running until an end-marker word.
- For each note it generates a square-wave tone for a duration measured in tempo ticks.
- Adds capabilities the previous player lacks: rests, loop mode, pause/resume, abort, runtime tempo, and a done pulse. Sits between the bus-side control registers and the buzzer pin.

---
 rtl/buzzer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_buzzer_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_sequencer.sv
// Single-voice buzzer sequencer: walks packed note words from a synchronous memory
// and drives a square-wave tone for DUR tempo ticks per note, with rest/loop/pause/stop.
module buzzer_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DIV_W  = 20,
    parameter int DUR_W  = 8,
    parameter int TICK_W = 24,
    localparam int WORD_W = 2 + DIV_W + DUR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [TICK_W-1:0] tick_period,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              note_strobe,
    output logic              beep
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_reg, addr_reg;
    logic              played_any;
    logic [DIV_W-1:0]  div_reg, tone_cnt;
    logic [DUR_W-1:0]  dur_rem;
    logic              rest_reg;
    logic [TICK_W-1:0] tick_per, tick_cnt;
    logic              beep_q;

    logic              w_end, w_rest;
    logic [DIV_W-1:0]  w_div;
    logic [DUR_W-1:0]  w_dur;
    logic              tick_wrap, note_end;

    assign w_end  = mem_rdata[WORD_W-1];
    assign w_rest = mem_rdata[WORD_W-2];
    assign w_div  = mem_rdata[DIV_W+DUR_W-1:DUR_W];
    assign w_dur  = mem_rdata[DUR_W-1:0];

    assign tick_wrap = (tick_cnt == tick_per - TICK_W'(1));
    assign note_end  = (state == PLAY) && !pause && tick_wrap && (dur_rem == DUR_W'(1));

    assign mem_rd   = (state == FETCH);
    assign mem_addr = addr_reg;
    assign busy     = (state != IDLE);
    // Pause silences the pin immediately; the register is cleared on the following edge.
    assign beep     = beep_q && !pause;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        done        = 1'b0;
        note_strobe = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                FETCH: state_nxt = LOAD;
                LOAD: begin
                    if (w_end) begin
                        if (loop_en && played_any) begin
                            state_nxt = FETCH;
                        end else begin
                            done      = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else if (w_dur == '0) begin
                        state_nxt = FETCH;
                    end else begin
                        note_strobe = 1'b1;
                        state_nxt   = PLAY;
                    end
                end
                PLAY: if (note_end) state_nxt = FETCH;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_reg   <= '0;
            addr_reg   <= '0;
            played_any <= 1'b0;
            div_reg    <= '0;
            tone_cnt   <= '0;
            dur_rem    <= '0;
            rest_reg   <= 1'b0;
            tick_per   <= '0;
            tick_cnt   <= '0;
            beep_q     <= 1'b0;
        end else if (stop) begin
            beep_q <= 1'b0;
        end else if (start) begin
            base_reg   <= start_addr;
            addr_reg   <= start_addr;
            played_any <= 1'b0;
            beep_q     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (w_end) begin
                        if (loop_en && played_any) addr_reg <= base_reg;
                    end else if (w_dur == '0) begin
                        addr_reg <= addr_reg + ADDR_W'(1);
                    end else begin
                        div_reg    <= w_div;
                        dur_rem    <= w_dur;
                        rest_reg   <= w_rest;
                        tick_per   <= (tick_period == '0) ? TICK_W'(1) : tick_period;
                        played_any <= 1'b1;
                        tone_cnt   <= '0;
                        tick_cnt   <= '0;
                        beep_q     <= 1'b0;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        beep_q <= 1'b0;
                    end else begin
                        if (rest_reg || div_reg == '0) begin
                            beep_q   <= 1'b0;
                            tone_cnt <= '0;
                        end else if (tone_cnt == div_reg - DIV_W'(1)) begin
                            tone_cnt <= '0;
                            beep_q   <= !beep_q;
                        end else begin
                            tone_cnt <= tone_cnt + DIV_W'(1);
                        end
                        if (tick_wrap) begin
                            tick_cnt <= '0;
                            dur_rem  <= dur_rem - DUR_W'(1);
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                        // Last tick of the last duration unit: silence and advance.
                        if (note_end) begin
                            beep_q   <= 1'b0;
                            addr_reg <= addr_reg + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer; cycle cN is the Nth cycle after the one in which start is high.
module tb_buzzer_sequencer;
    localparam int WORD_W = 30;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              pause = 1'b0;
    logic              loop_en = 1'b0;
    logic [7:0]        start_addr = '0;
    logic [23:0]       tick_period = '0;
    logic              mem_rd;
    logic [7:0]        mem_addr;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic              busy, done, note_strobe, beep;

    logic [WORD_W-1:0] mem [256];
    int total = 0;
    int bad = 0;

    buzzer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .start_addr(start_addr), .tick_period(tick_period),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .note_strobe(note_strobe), .beep(beep)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    function automatic logic [WORD_W-1:0] nw(bit e, bit r, int div, int dur);
        return {e, r, div[19:0], dur[7:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(logic [7:0] a);
        start_addr = a;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int toggles, hi, strobes, done_at, done_cnt, pre_hi, paused_hi, rest_hi;
        logic prev;

        for (int i = 0; i < 256; i++) mem[i] = nw(1, 0, 0, 0);
        mem[8'h00] = nw(0, 0, 3, 2);
        mem[8'h01] = nw(1, 0, 0, 0);
        mem[8'h10] = nw(0, 1, 5, 1);
        mem[8'h11] = nw(0, 0, 2, 0);
        mem[8'h12] = nw(0, 0, 2, 1);
        mem[8'h20] = nw(0, 0, 1, 1);
        mem[8'h21] = nw(0, 0, 1, 1);
        mem[8'h50] = nw(0, 0, 2, 3);
        mem[8'hFF] = nw(0, 0, 1, 1);

        // Reset state
        step();
        chk("rst_outs", {busy, beep, mem_rd, done, note_strobe, mem_addr}, 0);
        step();
        rst = 1'b0;
        step();
        chk("idle_outs", {busy, beep, mem_rd, done, note_strobe}, 0);

        // Single note DIV=3 DUR=2 tp=10: PLAY c3..c22, fetch END c23, done c24
        tick_period = 24'd10;
        pulse_start(8'h00);
        prev = 1'b0; toggles = 0; hi = 0; strobes = 0; done_at = 0;
        for (int n = 1; n <= 25; n++) begin
            if (n == 1) begin chk("sn_rd", mem_rd, 1); chk("sn_addr0", mem_addr, 0); end
            if (n == 2) chk("sn_strobe", note_strobe, 1);
            if (n >= 3 && n <= 22) begin
                if (beep !== prev) toggles++;
                prev = beep;
                if (beep) hi++;
            end
            if (n == 23) chk("sn_fetch1", {mem_rd, mem_addr}, {1'b1, 8'h01});
            if (note_strobe) strobes++;
            if (done && done_at == 0) done_at = n;
            if (n == 25) chk("sn_busy_low", busy, 0);
            step();
        end
        chk("sn_toggles", toggles, 6);
        chk("sn_hi", hi, 9);
        chk("sn_strobes", strobes, 1);
        chk("sn_done_at", done_at, 24);

        // Rest, skipped DUR=0 entry, one 4-cycle tone, END
        tick_period = 24'd4;
        pulse_start(8'h10);
        strobes = 0; hi = 0; rest_hi = 0; done_at = 0;
        for (int n = 1; n <= 17; n++) begin
            if (note_strobe) strobes++;
            if (beep) hi++;
            if (n >= 3 && n <= 6 && beep) rest_hi++;
            if (n == 9) chk("rs_fetch12", {mem_rd, mem_addr}, {1'b1, 8'h12});
            if (done && done_at == 0) done_at = n;
            step();
        end
        chk("rs_strobes", strobes, 2);
        chk("rs_rest_silent", rest_hi, 0);
        chk("rs_tone_hi", hi, 2);
        chk("rs_done_at", done_at, 16);

        // Loop: first pass wraps to base without done, second pass ends
        tick_period = 24'd2;
        loop_en = 1'b1;
        pulse_start(8'h20);
        done_cnt = 0; done_at = 0;
        for (int n = 1; n <= 21; n++) begin
            if (n == 12) loop_en = 1'b0;
            if (n == 11) chk("lp_refetch", {mem_rd, mem_addr}, {1'b1, 8'h20});
            if (done && n < 20) done_cnt++;
            if (n == 20) chk("lp_done", done, 1);
            if (n == 21) chk("lp_busy_low", busy, 0);
            step();
        end
        chk("lp_no_early_done", done_cnt, 0);

        // Empty looped song ends at c2
        loop_en = 1'b1;
        pulse_start(8'h30);
        step();
        chk("empty_done", done, 1);
        step();
        chk("empty_busy_low", busy, 0);
        loop_en = 1'b0;

        // Pause 50 cycles mid-note: PLAY c3..c112 instead of c3..c62
        tick_period = 24'd20;
        pulse_start(8'h50);
        pre_hi = 0; paused_hi = 0; done_at = 0;
        for (int n = 1; n <= 116; n++) begin
            if (n == 20) pause = 1'b1;
            if (n == 70) pause = 1'b0;
            if (n >= 3 && n <= 19 && beep) pre_hi++;
            if (pause && beep) paused_hi++;
            if (done && done_at == 0) done_at = n;
            step();
        end
        chk("pz_pre_hi", pre_hi, 8);
        chk("pz_silent", paused_hi, 0);
        chk("pz_done_at", done_at, 114);

        // Stop during PLAY
        pulse_start(8'h50);
        for (int n = 1; n <= 9; n++) step();
        chk("ab_beep_before", beep, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("ab_idle", {busy, beep}, 0);
        done_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            if (done) done_cnt++;
            step();
        end
        chk("ab_no_done", done_cnt, 0);

        // start and stop together: stop wins
        start_addr = 8'h50;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("ss_idle", {busy, mem_rd}, 0);

        // Restart while playing
        pulse_start(8'h50);
        for (int n = 1; n <= 9; n++) step();
        pulse_start(8'h40);
        chk("rs_restart_fetch", {mem_rd, mem_addr}, {1'b1, 8'h40});
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Address wrap 0xFF -> 0x00, tick_period 0 behaves as 1
        mem[8'h00] = nw(1, 0, 0, 0);
        tick_period = 24'd0;
        pulse_start(8'hFF);
        done_at = 0;
        for (int n = 1; n <= 6; n++) begin
            if (n == 1) chk("wr_addr_ff", {mem_rd, mem_addr}, {1'b1, 8'hFF});
            if (n == 4) chk("wr_addr_00", {mem_rd, mem_addr}, {1'b1, 8'h00});
            if (done && done_at == 0) done_at = n;
            step();
        end
        chk("wr_done_at", done_at, 5);

        // Async reset mid-note
        tick_period = 24'd20;
        pulse_start(8'h50);
        for (int n = 1; n <= 9; n++) step();
        chk("ar_beep_before", {busy, beep}, 2'b11);
        #1 rst = 1'b1;
        #1;
        chk("ar_cleared", {busy, beep, mem_rd, done, note_strobe, mem_addr}, 0);
        step();
        chk("ar_held", {busy, beep, mem_rd, done, note_strobe}, 0);
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
